hpi_bus_master: RTL

- Hardware initiator for the CY7C67200 host port interface (HPI).
- Converts a single-word req/ack request from FPGA logic into a correctly timed OTG_CS_N / OTG_RD_N / OTG_WR_N strobe sequence, and performs the chip reset pulse.
- Replaces the software-driven pass-through path, so game logic can read and write the USB controller without Nios involvement.
- Sits between the requesting logic and the OTG_* top-level pins.

---
 rtl/hpi_bus_master_if.sv | 19 +
 rtl/hpi_bus_master.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/hpi_bus_master_if.sv
`default_nettype none
// ============================================================================
// hpi_bus_master_if : request/response handshake between FPGA logic and HPI master
// Rev 1.0
// ============================================================================
interface hpi_bus_master_if;
   logic        req;
   logic        we;
   logic [1:0]  addr;
   logic [15:0] wdata;
   logic        rst_req;
   logic        ack;
   logic [15:0] rdata;
   logic        busy;

   modport master (output req, we, addr, wdata, rst_req, input ack, rdata, busy);
   modport slave  (input req, we, addr, wdata, rst_req, output ack, rdata, busy);
endinterface
`default_nettype wire

// File: rtl/hpi_bus_master.sv
`default_nettype none
// ============================================================================
// hpi_bus_master : single-word CY7C67200 HPI initiator with chip reset pulse
// Rev 1.0
// ============================================================================
module hpi_bus_master #(
   parameter int SETUP_CYC    = 2,
   parameter int STROBE_CYC   = 6,
   parameter int HOLD_CYC     = 2,
   parameter int RECOVERY_CYC = 4,
   parameter int RST_CYC      = 16
) (
   input  logic             Clk,
   input  logic             Reset_n,
   hpi_bus_master_if.slave  host,
   inout  wire  [15:0]      OTG_DATA,
   output logic [1:0]       OTG_ADDR,
   output logic             OTG_CS_N,
   output logic             OTG_RD_N,
   output logic             OTG_WR_N,
   output logic             OTG_RST_N
);

   // A phase of N cycles loads N-1 and exits when the counter reaches zero.
   localparam logic [7:0] SETUP_LD  = 8'(SETUP_CYC - 1);
   localparam logic [7:0] STROBE_LD = 8'(STROBE_CYC - 1);
   localparam logic [7:0] HOLD_LD   = 8'(HOLD_CYC - 1);
   localparam logic [7:0] RECOV_LD  = 8'(RECOVERY_CYC - 1);
   localparam logic [7:0] RST_LD    = 8'(RST_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SETUP  = 3'd1,
      S_STROBE = 3'd2,
      S_HOLD   = 3'd3,
      S_RECOV  = 3'd4,
      S_RSTP   = 3'd5
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic [1:0]  addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic [15:0] rdata_q, rdata_d;
   logic        oe_q, oe_d;
   logic        cs_n_q, cs_n_d;
   logic        rd_n_q, rd_n_d;
   logic        wr_n_q, wr_n_d;
   logic        otg_rst_n_q, otg_rst_n_d;
   logic        ack_q, ack_d;
   logic        phase_done;

   assign phase_done = (cnt_q == 8'd0);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q - 8'd1;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      oe_d        = oe_q;
      cs_n_d      = cs_n_q;
      rd_n_d      = 1'b1;
      wr_n_d      = 1'b1;
      otg_rst_n_d = 1'b1;
      ack_d       = 1'b0;

      case (state_q)
         S_IDLE: begin
            cnt_d = cnt_q;
            // Reset request wins; a simultaneous req is dropped, not queued.
            if (host.rst_req) begin
               state_d     = S_RSTP;
               cnt_d       = RST_LD;
               otg_rst_n_d = 1'b0;
            end else if (host.req) begin
               state_d = S_SETUP;
               cnt_d   = SETUP_LD;
               we_d    = host.we;
               addr_d  = host.addr;
               wdata_d = host.wdata;
               cs_n_d  = 1'b0;
               oe_d    = host.we;
            end
         end
         S_SETUP: begin
            if (phase_done) begin
               state_d = S_STROBE;
               cnt_d   = STROBE_LD;
               rd_n_d  = we_q;
               wr_n_d  = ~we_q;
            end
         end
         S_STROBE: begin
            if (phase_done) begin
               state_d = S_HOLD;
               cnt_d   = HOLD_LD;
               // Sampled while RD_N is still low on the edge that releases it.
               if (!we_q) begin
                  rdata_d = OTG_DATA;
               end
            end else begin
               rd_n_d = we_q;
               wr_n_d = ~we_q;
            end
         end
         S_HOLD: begin
            if (phase_done) begin
               state_d = S_RECOV;
               cnt_d   = RECOV_LD;
               cs_n_d  = 1'b1;
               oe_d    = 1'b0;
               ack_d   = 1'b1;
            end
         end
         S_RECOV: begin
            if (phase_done) begin
               state_d = S_IDLE;
               cnt_d   = 8'd0;
            end
         end
         S_RSTP: begin
            if (phase_done) begin
               state_d = S_RECOV;
               cnt_d   = RECOV_LD;
            end else begin
               otg_rst_n_d = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 8'd0;
            cs_n_d  = 1'b1;
            oe_d    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= 8'd0;
         we_q        <= 1'b0;
         addr_q      <= 2'd0;
         wdata_q     <= 16'd0;
         rdata_q     <= 16'd0;
         oe_q        <= 1'b0;
         cs_n_q      <= 1'b1;
         rd_n_q      <= 1'b1;
         wr_n_q      <= 1'b1;
         otg_rst_n_q <= 1'b1;
         ack_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         oe_q        <= oe_d;
         cs_n_q      <= cs_n_d;
         rd_n_q      <= rd_n_d;
         wr_n_q      <= wr_n_d;
         otg_rst_n_q <= otg_rst_n_d;
         ack_q       <= ack_d;
      end
   end

   assign OTG_DATA   = oe_q ? wdata_q : 16'hzzzz;
   assign OTG_ADDR   = addr_q;
   assign OTG_CS_N   = cs_n_q;
   assign OTG_RD_N   = rd_n_q;
   assign OTG_WR_N   = wr_n_q;
   assign OTG_RST_N  = otg_rst_n_q;
   assign host.ack   = ack_q;
   assign host.rdata = rdata_q;
   assign host.busy  = (state_q != S_IDLE);

endmodule
`default_nettype wire
